seg_scroll_mux: RTL and testbench

- Downstream consumer of the letter-sequencer stage's 8-bit active-low seven-segment codes.
- Each strobed code is shifted into an NDIG-deep character buffer, scrolling right to left.
- The buffer is time-multiplexed onto a common-anode multi-digit display with active-low anodes.
- Inter-digit blanking suppresses ghosting.

---
 rtl/seg_scroll_mux.sv | 83 ++++++++
 tb/tb_seg_scroll_mux.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scroll_mux.sv
// seg_scroll_mux: scrolling NDIG-character buffer, time-multiplexed onto a
// common-anode display (active-low anodes and segments) with per-slot blanking.
`default_nettype none

module seg_scroll_mux #(
  parameter int NDIG      = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic            ck,
  input  logic            rs,
  input  logic [7:0]      seg_in,
  input  logic            seg_valid,
  input  logic            clr,
  output logic [7:0]      seg,
  output logic [NDIG-1:0] an
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DW-1:0] C_DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] C_BLANK    = DW'(BLANK_CYC);
  localparam logic [IW-1:0] C_IDX_LAST = IW'(NDIG - 1);

  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [IW-1:0]   dig_idx_q, dig_idx_d;
  logic [7:0]      buf_q [NDIG];
  logic [7:0]      buf_d [NDIG];
  logic [7:0]      seg_q, seg_d;
  logic [NDIG-1:0] an_q, an_d;

  always_comb begin
    div_cnt_d = div_cnt_q + DW'(1);
    dig_idx_d = dig_idx_q;
    if (div_cnt_q == C_DIV_LAST) begin
      div_cnt_d = '0;
      dig_idx_d = (dig_idx_q == C_IDX_LAST) ? '0 : dig_idx_q + IW'(1);
    end
  end

  // clr beats seg_valid; the strobed code is dropped in that case.
  always_comb begin
    for (int k = 0; k < NDIG; k++) buf_d[k] = buf_q[k];
    if (clr) begin
      for (int k = 0; k < NDIG; k++) buf_d[k] = 8'hFF;
    end else if (seg_valid) begin
      buf_d[0] = seg_in;
      for (int k = 1; k < NDIG; k++) buf_d[k] = buf_q[k-1];
    end
  end

  // Outputs are built from pre-edge state, so a same-cycle write shows next cycle.
  always_comb begin
    an_d  = '1;
    seg_d = 8'hFF;
    if (div_cnt_q >= C_BLANK) begin
      an_d[dig_idx_q] = 1'b0;
      seg_d           = buf_q[dig_idx_q];
    end
  end

  always_ff @(posedge ck) begin
    if (!rs) begin
      div_cnt_q <= '0;
      dig_idx_q <= '0;
      seg_q     <= 8'hFF;
      an_q      <= '1;
      for (int k = 0; k < NDIG; k++) buf_q[k] <= 8'hFF;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_idx_q <= dig_idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      for (int k = 0; k < NDIG; k++) buf_q[k] <= buf_d[k];
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scroll_mux.sv
// tb_seg_scroll_mux: directed plus randomized stimulus checked against a
// cycle-count based reference model of the scrolling display.
`default_nettype none

module tb_seg_scroll_mux;

  localparam int NDIG      = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;

  logic            ck = 1'b0;
  logic            rs = 1'b0;
  logic [7:0]      seg_in = 8'hFF;
  logic            seg_valid = 1'b0;
  logic            clr = 1'b0;
  logic [7:0]      seg;
  logic [NDIG-1:0] an;

  int tests = 0;
  int fails = 0;

  // Reference model: elapsed cycles since reset plus a plain character array.
  int         m_t = 0;
  logic [7:0] m_chars [NDIG];
  logic [7:0]      exp_seg;
  logic [NDIG-1:0] exp_an;

  seg_scroll_mux #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .ck(ck), .rs(rs), .seg_in(seg_in), .seg_valid(seg_valid), .clr(clr),
    .seg(seg), .an(an)
  );

  always #5 ck = ~ck;

  task automatic check_outputs(input string tag);
    tests++;
    assert (an === exp_an) else begin
      fails++;
      $error("FAIL %s an: observed %h expected %h (t=%0d)", tag, an, exp_an, m_t);
    end
    tests++;
    assert (seg === exp_seg) else begin
      fails++;
      $error("FAIL %s seg: observed %h expected %h (t=%0d)", tag, seg, exp_seg, m_t);
    end
    tests++;
    assert ($countones(~an) <= 1) else begin
      fails++;
      $error("FAIL %s onehot: observed an=%h expected at most one low", tag, an);
    end
  endtask

  // One clock: apply inputs, predict outputs for this edge, advance model, check.
  task automatic step(input logic r, input logic v, input logic c,
                      input logic [7:0] d, input string tag);
    int slot, pos;
    @(negedge ck);
    rs = r; seg_valid = v; clr = c; seg_in = d;
    @(posedge ck);
    if (!r) begin
      exp_an  = '1;
      exp_seg = 8'hFF;
      m_t = 0;
      for (int k = 0; k < NDIG; k++) m_chars[k] = 8'hFF;
    end else begin
      pos  = m_t % SCAN_DIV;
      slot = (m_t / SCAN_DIV) % NDIG;
      if (pos < BLANK_CYC) begin
        exp_an  = '1;
        exp_seg = 8'hFF;
      end else begin
        exp_an  = ~(NDIG'(1) << slot);
        exp_seg = m_chars[slot];
      end
      m_t++;
      if (c) begin
        for (int k = 0; k < NDIG; k++) m_chars[k] = 8'hFF;
      end else if (v) begin
        for (int k = NDIG - 1; k > 0; k--) m_chars[k] = m_chars[k-1];
        m_chars[0] = d;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'hFF, tag);
  endtask

  task automatic load4(input string tag);
    step(1'b1, 1'b1, 1'b0, 8'h88, tag);
    step(1'b1, 1'b1, 1'b0, 8'h83, tag);
    step(1'b1, 1'b1, 1'b0, 8'hC6, tag);
    step(1'b1, 1'b1, 1'b0, 8'hA1, tag);
  endtask

  // Model-predicted anode pattern for the next edge, given no reset.
  function automatic logic [NDIG-1:0] next_an();
    if ((m_t % SCAN_DIV) < BLANK_CYC) return '1;
    return ~(NDIG'(1) << ((m_t / SCAN_DIV) % NDIG));
  endfunction

  initial begin
    logic [7:0] seen;
    bit found;

    for (int k = 0; k < NDIG; k++) m_chars[k] = 8'hFF;

    // Reset and idle scan
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'hFF, "reset");
    idle(32, "scan");

    // Load, then scroll one more character in
    load4("load");
    idle(16, "load_show");
    step(1'b1, 1'b1, 1'b0, 8'h86, "overflow");
    idle(16, "overflow_show");

    // Explicit directed checks: digit 3 now holds 83, 88 is gone
    seen = 8'h00;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'hFF, "ovf_scan");
      if (an == 4'h7) seen = seg;
    end
    tests++;
    assert (seen === 8'h83) else begin
      fails++;
      $error("FAIL ovf_digit3: observed %h expected %h", seen, 8'h83);
    end

    // Clear wins over a simultaneous strobe
    step(1'b1, 1'b1, 1'b1, 8'h8E, "clr_prio");
    idle(16, "clr_show");

    // Mid-scan reset while digit 1 is lit
    load4("reload");
    found = 1'b0;
    for (int i = 0; i < 32 && !found; i++) begin
      if (next_an() == 4'hD) found = 1'b1;
      else step(1'b1, 1'b0, 1'b0, 8'hFF, "seek_d");
    end
    tests++;
    assert (found) else begin
      fails++;
      $error("FAIL seek_d: observed no slot expected an=D within bound");
    end
    step(1'b1, 1'b0, 1'b0, 8'hFF, "pre_rst");
    tests++;
    assert (an === 4'hD) else begin
      fails++;
      $error("FAIL pre_rst_an: observed %h expected %h", an, 4'hD);
    end
    step(1'b0, 1'b0, 1'b0, 8'hFF, "mid_rst");
    idle(16, "after_rst");

    // Write while digit 0 displays A1
    load4("load3");
    found = 1'b0;
    for (int i = 0; i < 32 && !found; i++) begin
      if (next_an() == 4'hE && (m_t % SCAN_DIV) < SCAN_DIV - 1) found = 1'b1;
      else step(1'b1, 1'b0, 1'b0, 8'hFF, "seek_e");
    end
    tests++;
    assert (found) else begin
      fails++;
      $error("FAIL seek_e: observed no slot expected an=E within bound");
    end
    step(1'b1, 1'b1, 1'b0, 8'h86, "wdd_edge");
    tests++;
    assert (seg === 8'hA1 && an === 4'hE) else begin
      fails++;
      $error("FAIL wdd_old: observed an=%h seg=%h expected an=E seg=A1", an, seg);
    end
    step(1'b1, 1'b0, 1'b0, 8'hFF, "wdd_next");
    tests++;
    assert (seg === 8'h86 && an === 4'hE) else begin
      fails++;
      $error("FAIL wdd_new: observed an=%h seg=%h expected an=E seg=86", an, seg);
    end
    idle(8, "wdd_tail");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 24) == 0), 8'($urandom), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
